// File: rtl/flap_engine_n.sv
// Game engine for the VGA obstacle game: player box, N scrolling pipe pairs,
// LFSR gap placement, collision, scoring, IDLE/PLAY/OVER control and the
// combinational pixel colour generated against the registered game state.
module flap_engine_n #(
  parameter int unsigned N_PIPES     = 3,
  parameter int unsigned SPAWN_GAP   = 115,
  parameter int unsigned PIPE_HALF_W = 10,
  parameter int unsigned GAP_HALF    = 40,
  parameter int unsigned BOX_HALF_W  = 5,
  parameter int unsigned BOX_HALF_H  = 6,
  parameter int unsigned PIPE_STEP   = 2,
  parameter int unsigned RISE        = 4,
  parameter int unsigned FALL        = 3,
  parameter int unsigned SIDE_STEP   = 2,
  parameter int unsigned LEFT_B      = 113,
  parameter int unsigned RIGHT_B     = 751,
  parameter int unsigned TOP_B       = 36,
  parameter int unsigned BOT_B       = 514,
  parameter int unsigned SPAWN_X     = 763,
  parameter int unsigned GAP_MIN     = 90,
  parameter int unsigned GAP_MAX     = 460,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic               clkHz,
  input  logic               clr_n,
  input  logic               display_On,
  input  logic [9:0]         h_Counter,
  input  logic [9:0]         v_Counter,
  input  logic               btn_U,
  input  logic               btn_D,
  input  logic               btn_L,
  input  logic               btn_R,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               game_Over,
  output logic               playing,
  output logic [SCORE_W-1:0] score
);

  typedef logic [10:0] coord_t;
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  localparam coord_t PHW      = coord_t'(PIPE_HALF_W);
  localparam coord_t GH       = coord_t'(GAP_HALF);
  localparam coord_t BHW      = coord_t'(BOX_HALF_W);
  localparam coord_t BHH      = coord_t'(BOX_HALF_H);
  localparam coord_t PSTEP    = coord_t'(PIPE_STEP);
  localparam coord_t RISE_C   = coord_t'(RISE);
  localparam coord_t FALL_C   = coord_t'(FALL);
  localparam coord_t SIDE_C   = coord_t'(SIDE_STEP);
  localparam coord_t LEFT_C   = coord_t'(LEFT_B);
  localparam coord_t RIGHT_C  = coord_t'(RIGHT_B);
  localparam coord_t TOP_C    = coord_t'(TOP_B);
  localparam coord_t BOT_C    = coord_t'(BOT_B);
  localparam coord_t SPAWN_C  = coord_t'(SPAWN_X);
  localparam coord_t GMIN_C   = coord_t'(GAP_MIN);
  localparam coord_t GAP_SPAN = coord_t'(GAP_MAX - GAP_MIN);
  localparam coord_t GAP_WRAP = coord_t'(GAP_MAX - GAP_MIN + 1);
  localparam coord_t FLOOR_Y  = coord_t'(BOT_B - BOX_HALF_H);
  localparam coord_t HOME_X   = 11'd432;
  localparam coord_t HOME_Y   = 11'd271;
  localparam coord_t GC_HOME  = 11'd271;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int SUM_W = SCORE_W + 4;
  localparam logic [SUM_W-1:0] SCORE_MAX = {4'b0000, {SCORE_W{1'b1}}};

  // Fold a 9-bit random value into the legal gap-centre range.
  function automatic coord_t gap_draw(input logic [8:0] r9);
    coord_t r;
    r = {2'b00, r9};
    if (r > GAP_SPAN) r = r - GAP_WRAP;
    return GMIN_C + r;
  endfunction

  state_t               state_q, state_d;
  coord_t               box_x_q, box_x_d, box_y_q, box_y_d;
  coord_t               px_q [N_PIPES];
  coord_t               px_d [N_PIPES];
  coord_t               gc_q [N_PIPES];
  coord_t               gc_d [N_PIPES];
  logic [N_PIPES-1:0]   active_q, active_d, passed_q, passed_d;
  logic [15:0]          tick_q, tick_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic                 game_over_q, playing_q;

  coord_t               box_l_q, box_r_q, box_t_q, box_b_q;
  coord_t               box_l_nxt, y_fall;
  logic                 hit;
  logic [3:0]           n_pass;
  logic [SUM_W-1:0]     score_sum;
  coord_t               hpix, vpix;
  logic                 pipe_px, box_px;

  assign box_l_q = box_x_q - BHW;
  assign box_r_q = box_x_q + BHW;
  assign box_t_q = box_y_q - BHH;
  assign box_b_q = box_y_q + BHH;

  // Collision of the registered box against the floor and every active pipe.
  always_comb begin
    hit = (box_b_q >= BOT_C);
    for (int i = 0; i < N_PIPES; i++) begin
      if (active_q[i] && (box_r_q > px_q[i] - PHW) && (box_l_q < px_q[i] + PHW) &&
          !((box_t_q >= gc_q[i] - GH) && (box_b_q <= gc_q[i] + GH)))
        hit = 1'b1;
    end
  end

  // Next-state logic: one game tick of the IDLE/PLAY/OVER machine.
  always_comb begin
    // NOTE: every _d gets its hold value first so no branch can leave a latch.
    state_d   = state_q;
    box_x_d   = box_x_q;
    box_y_d   = box_y_q;
    px_d      = px_q;
    gc_d      = gc_q;
    active_d  = active_q;
    passed_d  = passed_q;
    tick_d    = tick_q;
    score_d   = score_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    y_fall    = box_y_q + FALL_C;
    box_l_nxt = box_l_q;
    n_pass    = '0;
    score_sum = '0;

    case (state_q)
      S_IDLE: begin
        if (btn_U) begin
          state_d = S_PLAY;
          tick_d  = '0;
        end
      end

      S_PLAY: begin
        if (hit) begin
          state_d = S_OVER;
        end else begin
          if (btn_U && (box_t_q > TOP_C)) box_y_d = box_y_q - RISE_C;
          else                            box_y_d = (y_fall > FLOOR_Y) ? FLOOR_Y : y_fall;

          // Left and right are judged on the current box, so both held cancel.
          if (btn_L && (box_l_q > LEFT_C))  box_x_d = box_x_d - SIDE_C;
          if (btn_R && (box_r_q < RIGHT_C)) box_x_d = box_x_d + SIDE_C;
          box_l_nxt = box_x_d - BHW;

          for (int i = 0; i < N_PIPES; i++) begin
            if (32'(tick_q) >= i * SPAWN_GAP) active_d[i] = 1'b1;
            if (active_d[i]) begin
              if (px_q[i] + PHW > LEFT_C) begin
                px_d[i] = px_q[i] - PSTEP;
              end else begin
                px_d[i]     = SPAWN_C;
                gc_d[i]     = gap_draw(lfsr_q[8:0]);
                passed_d[i] = 1'b0;
              end
              // Passing is judged on the moved pipe against the moved box.
              if (!passed_d[i] && (px_d[i] + PHW < box_l_nxt)) begin
                passed_d[i] = 1'b1;
                n_pass      = n_pass + 4'd1;
              end
            end
          end

          score_sum = SUM_W'(score_q) + SUM_W'(n_pass);
          score_d   = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
          tick_d    = (tick_q == 16'hFFFF) ? tick_q : tick_q + 16'd1;
        end
      end

      S_OVER: begin
        if (btn_D) begin
          state_d  = S_IDLE;
          box_x_d  = HOME_X;
          box_y_d  = HOME_Y;
          for (int i = 0; i < N_PIPES; i++) begin
            px_d[i] = SPAWN_C;
            gc_d[i] = GC_HOME;
          end
          active_d = '0;
          passed_d = '0;
          tick_d   = '0;
          score_d  = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Game state register, cleared asynchronously to the IDLE reset image.
  always_ff @(posedge clkHz or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_IDLE;
      box_x_q     <= HOME_X;
      box_y_q     <= HOME_Y;
      // NOTE: the pipe arrays are ordinary flops, not RAM, so they take the reset image too.
      for (int i = 0; i < N_PIPES; i++) begin
        px_q[i] <= SPAWN_C;
        gc_q[i] <= GC_HOME;
      end
      active_q    <= '0;
      passed_q    <= '0;
      tick_q      <= '0;
      score_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      game_over_q <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q     <= state_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      px_q        <= px_d;
      gc_q        <= gc_d;
      active_q    <= active_d;
      passed_q    <= passed_d;
      tick_q      <= tick_d;
      score_q     <= score_d;
      lfsr_q      <= lfsr_d;
      game_over_q <= (state_d == S_OVER);
      playing_q   <= (state_d == S_PLAY);
    end
  end

  assign game_Over = game_over_q;
  assign playing   = playing_q;
  assign score     = score_q;

  assign hpix = {1'b0, h_Counter};
  assign vpix = {1'b0, v_Counter};

  // Pixel colour: pipes and box in black over a white (or red when over) field.
  always_comb begin
    pipe_px = 1'b0;
    for (int i = 0; i < N_PIPES; i++) begin
      if (active_q[i] && (hpix > px_q[i] - PHW) && (hpix < px_q[i] + PHW) &&
          (((vpix > gc_q[i] + GH) && (vpix < BOT_C)) ||
           ((vpix > TOP_C) && (vpix < gc_q[i] - GH))))
        pipe_px = 1'b1;
    end
    box_px = (state_q != S_OVER) && (hpix > box_l_q) && (hpix < box_r_q) &&
             (vpix > box_t_q) && (vpix < box_b_q);
    red   = 4'h0;
    green = 4'h0;
    blue  = 4'h0;
    if (display_On && !(pipe_px || box_px)) begin
      red = 4'hF;
      if (state_q != S_OVER) begin
        green = 4'hF;
        blue  = 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_flap_engine_n.sv
// Bench for flap_engine_n: directed start/descent/restart/reset sequences plus
// randomized play steered by an autopilot, all checked against a tick-level
// behavioural model of the game kept in plain integers.
`timescale 1ns/1ps
module tb_flap_engine_n;

  localparam int NP    = 3;
  localparam int SGAP  = 115;
  localparam int PHW   = 10;
  localparam int GH    = 40;
  localparam int BHW   = 5;
  localparam int BHH   = 6;
  localparam int LEFT  = 113;
  localparam int RIGHT = 751;
  localparam int TOP   = 36;
  localparam int BOT   = 514;
  localparam int SPX   = 763;
  localparam int GMIN  = 90;
  localparam int GMAX  = 460;

  logic       clkHz = 1'b0;
  logic       clr_n = 1'b0;
  logic       display_On = 1'b0;
  logic [9:0] h_Counter = '0;
  logic [9:0] v_Counter = '0;
  logic       btn_U = 1'b0, btn_D = 1'b0, btn_L = 1'b0, btn_R = 1'b0;
  logic [3:0] red, green, blue;
  logic       game_Over, playing;
  logic [7:0] score;

  flap_engine_n dut (
    .clkHz      (clkHz),
    .clr_n      (clr_n),
    .display_On (display_On),
    .h_Counter  (h_Counter),
    .v_Counter  (v_Counter),
    .btn_U      (btn_U),
    .btn_D      (btn_D),
    .btn_L      (btn_L),
    .btn_R      (btn_R),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .game_Over  (game_Over),
    .playing    (playing),
    .score      (score)
  );

  always #100 clkHz = ~clkHz;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (0 idle, 1 play, 2 over) -------------
  int          m_st, m_bx, m_by, m_tick, m_score;
  int          m_px [NP];
  int          m_gc [NP];
  bit          m_act [NP];
  bit          m_pas [NP];
  logic [15:0] m_lfsr;

  function automatic int draw(input logic [15:0] l);
    int r;
    r = int'(l[8:0]);
    if (r > GMAX - GMIN) r = r - (GMAX - GMIN + 1);
    return GMIN + r;
  endfunction

  task automatic model_reset(input bit keep_lfsr);
    m_st = 0; m_bx = 432; m_by = 271; m_tick = 0; m_score = 0;
    for (int i = 0; i < NP; i++) begin
      m_px[i] = SPX; m_gc[i] = 271; m_act[i] = 0; m_pas[i] = 0;
    end
    if (!keep_lfsr) m_lfsr = 16'hACE1;
  endtask

  task automatic model_step(input bit u, input bit d, input bit l, input bit r);
    logic [15:0] nl;
    bit hit;
    int dx, newly;
    nl = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    case (m_st)
      0: if (u) begin m_st = 1; m_tick = 0; end
      1: begin
        hit = (m_by + BHH >= BOT);
        for (int i = 0; i < NP; i++)
          if (m_act[i] && m_bx + BHW > m_px[i] - PHW && m_bx - BHW < m_px[i] + PHW &&
              !(m_by - BHH >= m_gc[i] - GH && m_by + BHH <= m_gc[i] + GH))
            hit = 1;
        if (hit) m_st = 2;
        else begin
          if (u && m_by - BHH > TOP) m_by = m_by - 4;
          else m_by = (m_by + 3 > BOT - BHH) ? BOT - BHH : m_by + 3;
          dx = 0;
          if (l && m_bx - BHW > LEFT)  dx = dx - 2;
          if (r && m_bx + BHW < RIGHT) dx = dx + 2;
          m_bx = m_bx + dx;
          for (int i = 0; i < NP; i++) begin
            if (m_tick >= i * SGAP) m_act[i] = 1;
            if (m_act[i]) begin
              if (m_px[i] + PHW > LEFT) m_px[i] = m_px[i] - 2;
              else begin m_px[i] = SPX; m_gc[i] = draw(m_lfsr); m_pas[i] = 0; end
            end
          end
          newly = 0;
          for (int i = 0; i < NP; i++)
            if (m_act[i] && !m_pas[i] && m_px[i] + PHW < m_bx - BHW) begin
              m_pas[i] = 1; newly++;
            end
          m_score = (m_score + newly > 255) ? 255 : m_score + newly;
          if (m_tick < 65535) m_tick++;
        end
      end
      default: if (d) model_reset(1'b1);
    endcase
    m_lfsr = nl;
  endtask

  function automatic int exp_pix(input int h, input int v, input bit disp);
    bit dark = 0;
    if (!disp) return 0;
    for (int i = 0; i < NP; i++)
      if (m_act[i] && h > m_px[i] - PHW && h < m_px[i] + PHW &&
          ((v > m_gc[i] + GH && v < BOT) || (v > TOP && v < m_gc[i] - GH)))
        dark = 1;
    if (m_st != 2 && h > m_bx - BHW && h < m_bx + BHW && v > m_by - BHH && v < m_by + BHH)
      dark = 1;
    if (dark) return 0;
    return (m_st == 2) ? 12'hF00 : 12'hFFF;
  endfunction

  // Gap centre of the nearest pipe whose column the box has not yet cleared.
  function automatic int target_y();
    int best = -1, bp = 100000;
    for (int i = 0; i < NP; i++)
      if (m_act[i] && m_px[i] + PHW >= m_bx - BHW && m_px[i] < bp) begin
        bp = m_px[i]; best = i;
      end
    return (best < 0) ? 271 : m_gc[best];
  endfunction

  // ---------------- compare process: status and pixels every tick ----------
  int ph[$];
  int pv[$];

  initial begin : compare
    bit disp;
    forever begin
      @(posedge clkHz);
      #2;
      if (cmp_en) begin
        check("game_Over", game_Over, m_st == 2);
        check("playing", playing, m_st == 1);
        check("score", score, m_score);
        ph.delete(); pv.delete();
        ph.push_back(m_bx);           pv.push_back(m_by);
        ph.push_back(m_bx - BHW);     pv.push_back(m_by);
        ph.push_back(m_bx - BHW + 1); pv.push_back(m_by);
        ph.push_back(m_bx + BHW - 1); pv.push_back(m_by);
        ph.push_back(m_bx + BHW);     pv.push_back(m_by);
        ph.push_back(m_bx);           pv.push_back(m_by - BHH);
        ph.push_back(m_bx);           pv.push_back(m_by - BHH + 1);
        ph.push_back(m_bx);           pv.push_back(m_by + BHH - 1);
        ph.push_back(m_bx);           pv.push_back(m_by + BHH);
        for (int i = 0; i < NP; i++) begin
          ph.push_back(m_px[i] - PHW);     pv.push_back(40);
          ph.push_back(m_px[i] - PHW + 1); pv.push_back(40);
          ph.push_back(m_px[i] + PHW - 1); pv.push_back(40);
          ph.push_back(m_px[i] + PHW);     pv.push_back(40);
          ph.push_back(m_px[i]); pv.push_back(m_gc[i] - GH);
          ph.push_back(m_px[i]); pv.push_back(m_gc[i] - GH - 1);
          ph.push_back(m_px[i]); pv.push_back(m_gc[i] + GH);
          ph.push_back(m_px[i]); pv.push_back(m_gc[i] + GH + 1);
          ph.push_back(m_px[i]); pv.push_back(BOT - 1);
          ph.push_back(m_px[i]); pv.push_back(BOT);
          ph.push_back(m_px[i]); pv.push_back(TOP + 1);
          ph.push_back(m_px[i]); pv.push_back(TOP);
        end
        ph.push_back(int'($urandom_range(799))); pv.push_back(int'($urandom_range(524)));
        ph.push_back(int'($urandom_range(799))); pv.push_back(int'($urandom_range(524)));
        for (int k = 0; k < ph.size(); k++) begin
          disp       = ($urandom_range(9) != 0);
          h_Counter  = 10'(ph[k]);
          v_Counter  = 10'(pv[k]);
          display_On = disp;
          #1;
          check($sformatf("pixel(%0d,%0d)", ph[k], pv[k]), int'({red, green, blue}),
                exp_pix(ph[k], pv[k], disp));
        end
      end
    end
  end

  // ---------------- stimulus -------------------------------------------------
  // Called between edges: drive buttons, let one tick happen, advance the model.
  task automatic tick(input bit u, input bit d, input bit l, input bit r);
    btn_U = u; btn_D = d; btn_L = l; btn_R = r;
    @(posedge clkHz);
    model_step(u, d, l, r);
    @(negedge clkHz);
  endtask

  initial begin : driver
    int n, max_score;
    bit u, d, l, r, reckless;
    max_score = 0;
    reckless  = 0;
    model_reset(1'b0);
    @(negedge clkHz);
    check("reset_game_Over", game_Over, 0);
    check("reset_playing", playing, 0);
    check("reset_score", score, 0);
    clr_n  = 1'b1;
    cmp_en = 1'b1;

    // Gap-draw folding pinned by hand.
    check("draw_400", draw(16'h0190), 119);
    check("draw_100", draw(16'h0064), 190);

    // Start, then one held-up tick in PLAY.
    tick(1, 0, 0, 0);
    check("start_playing", playing, 1);
    tick(1, 0, 0, 0);
    check("start_box_y", m_by, 267);
    check("start_pipe0_x", m_px[0], 761);

    // Free fall to the floor: clamp after 81 ticks, OVER on the 82nd.
    n = 0;
    do begin
      tick(0, 0, 0, 0);
      n++;
    end while (!game_Over && n < 200);
    check("descent_ticks", n, 82);
    check("descent_box_y", m_by, 508);
    check("descent_pipe0_x", m_px[0], 599);
    check("descent_score", score, 0);

    // btn_U is ignored in OVER; btn_D restarts to the reset image.
    tick(1, 0, 0, 0);
    check("over_ignores_up", game_Over, 1);
    tick(0, 1, 0, 0);
    check("restart_playing", playing, 0);
    check("restart_game_Over", game_Over, 0);
    check("restart_box_x", m_bx, 432);
    check("restart_box_y", m_by, 271);
    check("restart_pipe0_x", m_px[0], 763);

    // Randomized play steered through the gaps, with occasional crashes.
    for (int t = 0; t < 6000; t++) begin
      u = 0; d = 0;
      l = ($urandom_range(5) == 0);
      r = ($urandom_range(5) == 0);
      case (m_st)
        0: begin
          u = ($urandom_range(7) == 0);
          reckless = ($urandom_range(3) == 0);
        end
        1: begin
          if (reckless) u = ($urandom_range(2) == 0);
          else begin
            u = (m_by > target_y());
            if ($urandom_range(39) == 0) u = !u;
          end
        end
        default: begin
          d = ($urandom_range(5) == 0);
          u = 1'($urandom_range(1));
        end
      endcase
      tick(u, d, l, r);
      if (int'(score) > max_score) max_score = int'(score);
    end
    check("scored_some_pipes", int'(max_score > 0), 1);

    // Asynchronous clear in the middle of PLAY.
    for (int k = 0; k < 60 && m_st != 1; k++) tick(m_st == 0, m_st == 2, 0, 0);
    repeat (5) tick(0, 0, 0, 0);
    check("pre_clear_playing", playing, 1);
    #50;
    clr_n = 1'b0;
    model_reset(1'b0);
    #1;
    check("async_clear_playing", playing, 0);
    check("async_clear_game_Over", game_Over, 0);
    check("async_clear_score", score, 0);
    @(negedge clkHz);
    clr_n = 1'b1;
    repeat (20) tick(($urandom_range(3) == 0), 0, 0, 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flap_engine_n.md
# flap_engine_n

Parametrised game-engine block for the VGA obstacle game. It holds the player box and N scrolling pipe pairs, and advances them once per `clkHz` edge (one game tick). It randomises gap positions with an LFSR, detects pipe and floor collisions, keeps a score, and runs an IDLE/PLAY/OVER state machine. Pixel colour is produced combinationally from the shared VGA timing counters. It sits between the VGA sync generator and the RGB output pins.

## Interface
- `N_PIPES`, 3: number of pipe pairs, 1..8
- `SPAWN_GAP`, 115: ticks between successive pipe activations
- `PIPE_HALF_W`, 10: pipe half-width in pixels
- `GAP_HALF`, 40: half-height of the pipe opening
- `BOX_HALF_W` / `BOX_HALF_H`, 5 / 6: player box half-extents
- `PIPE_STEP`, 2: pipe leftward motion per tick
- `RISE` / `FALL` / `SIDE_STEP`, 4 / 3 / 2: box motion per tick
- `LEFT_B` / `RIGHT_B` / `TOP_B` / `BOT_B`, 113 / 751 / 36 / 514: playfield bounds
- `SPAWN_X`, 763: pipe centre x at spawn
- `GAP_MIN` / `GAP_MAX`, 90 / 460: range of the gap centre
- `SCORE_W`, 8: score width

Ports:
- `clkHz` in 1: game-tick clock
- `clr_n` in 1: asynchronous, active-low reset
- `display_On` in 1: active-video flag
- `h_Counter`, `v_Counter` in 10: pixel position, zero-extended to 11 bits internally
- `btn_U`, `btn_D`, `btn_L`, `btn_R` in 1: debounced buttons, synchronous to `clkHz`
- `red`, `green`, `blue` out 4: pixel colour
- `game_Over` out 1: high in OVER
- `playing` out 1: high in PLAY
- `score` out `SCORE_W`: pipes passed

## Operation
**Arithmetic.** All coordinates are 11-bit unsigned registers. Pipe i has a centre x `px[i]`, a gap centre `gc[i]`, an active flag and a passed flag.

**Reset (`clr_n` low, asynchronous).** Reset puts the block into the IDLE reset image:
- State IDLE.
- Box at (432, 271).
- Every `px` = `SPAWN_X`, every `gc` = 271, all active and passed flags clear.
- Tick counter 0, score 0.
- LFSR = 16'hACE1.
- `game_Over` = 0, `playing` = 0.

**LFSR.** 16-bit Fibonacci LFSR with taps 16, 14, 13, 11. It advances every tick in every state.
- Gap draw: r = lfsr[8:0]; if r > GAP_MAX − GAP_MIN, subtract (GAP_MAX − GAP_MIN + 1); gc = GAP_MIN + r.

**IDLE.**
- Only the LFSR advances.
- `btn_U` → PLAY on the next tick. The tick counter starts at 0.

**PLAY, one tick, in this order.**
1. **Collision check** on the current registered values.
   - Pipe hit for pipe i: box_R > px−PIPE_HALF_W and box_L < px+PIPE_HALF_W, and NOT (box_T ≥ gc−GAP_HALF and box_B ≤ gc+GAP_HALF).
   - Floor hit: box_B ≥ BOT_B.
   - Any hit → OVER. Nothing moves this tick, and the score is frozen.
2. **Box vertical.**
   - `btn_U` and box_T > TOP_B: y −= RISE.
   - Else: y = min(y+FALL, BOT_B−BOX_HALF_H).
3. **Box horizontal.**
   - `btn_L` and box_L > LEFT_B: x −= SIDE_STEP.
   - `btn_R` and box_R < RIGHT_B: x += SIDE_STEP.
   - Both pressed: net zero.
4. **Pipe activation.** Pipe i becomes active when tick counter ≥ i·SPAWN_GAP. Once set, the active flag stays set until reset or restart.
5. **Active pipe motion.**
   - If px+PIPE_HALF_W > LEFT_B: px −= PIPE_STEP.
   - Else respawn: px = SPAWN_X, gc = new draw, passed flag cleared.
6. **Scoring.** When an active pipe that is not yet passed satisfies px+PIPE_HALF_W < box_L, set its passed flag.
   - Score += number of pipes newly passed this tick.
   - The score saturates at all-ones.
7. **Tick counter.** Increments and saturates at 16'hFFFF.

**OVER.**
- All positions are frozen.
- `btn_D` → IDLE with the reset image, except the LFSR, which keeps running.
- `btn_U` is ignored in OVER.

**Render (combinational).**
- `display_On` = 0: all colour channels 0.
- Pipe pixel: strictly inside the column and either v > gc+GAP_HALF and v < BOT_B, or v > TOP_B and v < gc−GAP_HALF. Pipes are drawn only when active.
- Box pixel: strictly inside the box edges.
- Colours:
  - Pipe or box pixel: black (0, 0, 0).
  - Otherwise: white (F, F, F) in IDLE/PLAY, or red (F, 0, 0) in OVER.
  - The box is not drawn in OVER.

## Timing
- All state is registered on `clkHz` rising edges. Only `clr_n` acts asynchronously.
- `game_Over`, `playing` and `score` are registered and valid on the tick after the event that causes them.
- Colour outputs have zero latency from the pixel counters, against the registered state.
- Button-to-motion latency is one tick.
- A collision is detected and takes effect on the tick after the move that caused the overlap.
- `clr_n` asserted mid-PLAY reaches the reset image immediately. Release is synchronised by the system.

## Test plan
- **Reset, then start.** Reset, hold `btn_U` for 1 tick → `playing` = 1. Box moves to y = 267. Pipe 0 is at 761 after 1 tick.
- **Idle descent.** Idle in PLAY (N_PIPES = 1) for 81 ticks → box_B clamps to 514. One tick later `game_Over` = 1 and the background reads red.
- **Gap draw.** Force LFSR[8:0] = 400 at respawn → gc = 119. Force 100 → gc = 190.
- **Pipe hit.** Place the box at y = 271 with the pipe gap at 400, and let the pipe arrive → OVER on the first overlapping tick. `score` is unchanged.
- **Scoring through a gap.** Hold the box inside the gap as pipe 0 passes → `score` 0→1 exactly once. Set SCORE_W = 1 and pass 3 pipes → `score` saturates at 1.
- **Restart and reset mid-game.** `btn_D` in OVER → reset image: box (432, 271), pipes at 763, score 0. Pull `clr_n` low mid-PLAY → outputs reset without a clock edge.
